// File: rtl/alu_5bit.sv
// 5-bit two-operand ALU (ADD/SUB/AND/OR) with registered result and carry/sign/zero flags.
// Latency 1 cycle; no backpressure, a new operation is accepted every cycle.
module alu_5bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic [1:0] op,
  output logic [4:0] R,
  output logic       cf,
  output logic       sf,
  output logic       zf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef struct packed {
    logic [4:0] res;
    logic       cf;
    logic       sf;
    logic       zf;
  } alu_out_t;

  localparam alu_out_t RST_VAL = '{res: 5'b00000, cf: 1'b0, sf: 1'b0, zf: 1'b1};

  logic [5:0] sum;
  logic [5:0] diff;
  logic [4:0] res_nxt;
  logic       cf_nxt;
  alu_out_t   nxt_dat;
  alu_out_t   out_q;

  // Six-bit arithmetic: bit 5 of sum is the carry, bit 5 of diff is set
  // exactly when a < b because the subtraction wraps negative.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    res_nxt = 5'b00000;
    cf_nxt  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        res_nxt = sum[4:0];
        cf_nxt  = sum[5];
      end
      OP_SUB: begin
        res_nxt = diff[4:0];
        cf_nxt  = diff[5];
      end
      OP_AND: res_nxt = a & b;
      OP_OR:  res_nxt = a | b;
      default: begin
        res_nxt = 5'b00000;
        cf_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    nxt_dat     = RST_VAL;
    nxt_dat.res = res_nxt;
    nxt_dat.cf  = cf_nxt;
    nxt_dat.sf  = res_nxt[4];
    nxt_dat.zf  = ~|res_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RST_VAL;
    end else begin
      out_q <= nxt_dat;
    end
  end

  assign R  = out_q.res;
  assign cf = out_q.cf;
  assign sf = out_q.sf;
  assign zf = out_q.zf;

endmodule

// File: tb/tb_alu_5bit.sv
// Directed bench for alu_5bit; expected {R,cf,sf,zf} vectors are hand-computed.
module tb_alu_5bit;

  logic       clk;
  logic       rst;
  logic [4:0] a;
  logic [4:0] b;
  logic [1:0] op;
  logic [4:0] R;
  logic       cf;
  logic       sf;
  logic       zf;

  int n_checks;
  int n_fail;

  alu_5bit dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .op (op),
    .R  (R),
    .cf (cf),
    .sf (sf),
    .zf (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic [4:0] av, input logic [4:0] bv, input logic [1:0] ov);
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    op  = ov;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] obs;
    drive(1'b1, 5'b11011, 5'b00111, 2'b00);
    obs = {R, cf, sf, zf};
    n_checks++;
    if (obs !== 8'b00000_0_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got %b, expected %b", obs, 8'b00000_0_0_1);
    end
    drive(1'b0, 5'b00011, 5'b00100, 2'b00);
    obs = {R, cf, sf, zf};
    n_checks++;
    if (obs !== 8'b00111_0_0_0) begin
      n_fail++;
      $display("FAIL reset_release: got %b, expected %b", obs, 8'b00111_0_0_0);
    end
  endtask

  task automatic test_add;
    logic [4:0] av [4];
    logic [4:0] bv [4];
    logic [7:0] ex [4];
    logic [7:0] obs;
    av = '{5'b10101, 5'b11111, 5'b01111, 5'b00000};
    bv = '{5'b10001, 5'b00001, 5'b00001, 5'b00000};
    ex = '{8'b00110_1_0_0, 8'b00000_1_0_1, 8'b10000_0_1_0, 8'b00000_0_0_1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, av[i], bv[i], 2'b00);
      obs = {R, cf, sf, zf};
      n_checks++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL add_%0d: got %b, expected %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_sub;
    logic [4:0] av [4];
    logic [4:0] bv [4];
    logic [7:0] ex [4];
    logic [7:0] obs;
    av = '{5'b10101, 5'b00011, 5'b01010, 5'b00000};
    bv = '{5'b10001, 5'b00101, 5'b01010, 5'b00001};
    ex = '{8'b00100_0_0_0, 8'b11110_1_1_0, 8'b00000_0_0_1, 8'b11111_1_1_0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, av[i], bv[i], 2'b01);
      obs = {R, cf, sf, zf};
      n_checks++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL sub_%0d: got %b, expected %b", i, obs, ex[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [4:0] av [4];
    logic [4:0] bv [4];
    logic [1:0] ov [4];
    logic [7:0] ex [4];
    logic [7:0] obs;
    av = '{5'b10101, 5'b10101, 5'b01010, 5'b01010};
    bv = '{5'b10001, 5'b10001, 5'b10101, 5'b00100};
    ov = '{2'b10, 2'b11, 2'b10, 2'b11};
    ex = '{8'b10001_0_1_0, 8'b10101_0_1_0, 8'b00000_0_0_1, 8'b01110_0_0_0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, av[i], bv[i], ov[i]);
      obs = {R, cf, sf, zf};
      n_checks++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL logic_%0d: got %b, expected %b", i, obs, ex[i]);
      end
    end
  endtask

  // Each result must appear only after its own edge: before the edge the previous one is held.
  task automatic test_back_to_back;
    logic [7:0] ex [4];
    logic [7:0] prev;
    logic [7:0] obs;
    ex = '{8'b00110_1_0_0, 8'b00100_0_0_0, 8'b10001_0_1_0, 8'b10101_0_1_0};
    drive(1'b0, 5'b00000, 5'b00001, 2'b01);
    prev = 8'b11111_1_1_0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      a   = 5'b10101;
      b   = 5'b10001;
      op  = 2'(i);
      #1;
      obs = {R, cf, sf, zf};
      n_checks++;
      if (obs !== prev) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: got %b, expected %b", i, obs, prev);
      end
      @(posedge clk);
      #1;
      obs = {R, cf, sf, zf};
      n_checks++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: got %b, expected %b", i, obs, ex[i]);
      end
      prev = ex[i];
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] obs;
    drive(1'b0, 5'b10101, 5'b00000, 2'b11);
    obs = {R, cf, sf, zf};
    n_checks++;
    if (obs !== 8'b10101_0_1_0) begin
      n_fail++;
      $display("FAIL mid_pre: got %b, expected %b", obs, 8'b10101_0_1_0);
    end
    drive(1'b1, 5'b11111, 5'b00001, 2'b00);
    obs = {R, cf, sf, zf};
    n_checks++;
    if (obs !== 8'b00000_0_0_1) begin
      n_fail++;
      $display("FAIL mid_reset: got %b, expected %b", obs, 8'b00000_0_0_1);
    end
    drive(1'b0, 5'b11111, 5'b00001, 2'b00);
    obs = {R, cf, sf, zf};
    n_checks++;
    if (obs !== 8'b00000_1_0_1) begin
      n_fail++;
      $display("FAIL mid_after: got %b, expected %b", obs, 8'b00000_1_0_1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    a        = 5'b00000;
    b        = 5'b00000;
    op       = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_5bit.md
Name: alu_5bit

Overview:
- 5-bit, two-operand ALU with registered result and status flags (carry/borrow, sign, zero).
- Used as the arithmetic/logic execution unit of the small CPU datapath.
- Combinational compute stage; result and flags captured on the clock edge.
- One clock, synchronous active-high reset.

Parameters:
- None. Data width fixed at 5 bits; opcode width fixed at 2 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- a    input  5  operand A, unsigned 5-bit.
- b    input  5  operand B, unsigned 5-bit.
- op   input  2  operation select.
- R    output 5  registered result.
- cf   output 1  registered carry (ADD) / borrow (SUB) flag.
- sf   output 1  registered sign flag.
- zf   output 1  registered zero flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, R=5'b00000, cf=0, sf=0, zf=1 (flags consistent with R=0). rst has priority over all other inputs. A reset asserted mid-stream discards that cycle's computation.
- Latency: exactly 1 cycle. Inputs a, b and op are sampled at rising edge N, and R/cf/sf/zf reflect them after edge N. Outputs hold between edges. No handshake; a new operation is accepted every cycle.
- Opcodes:
  - 00 ADD: 6-bit sum = a + b. R = sum[4:0]. cf = sum[5] (unsigned carry out).
  - 01 SUB: R = (a - b) mod 32. cf = 1 iff a < b unsigned (borrow). cf = 0 when a >= b, including a == b.
  - 10 AND: R = a & b, bitwise. cf = 0.
  - 11 OR: R = a | b, bitwise. cf = 0.
- Flags are computed from the 5-bit result of the same operation and registered with R:
  - sf = R[4].
  - zf = 1 iff R == 5'b00000.
- No signed-overflow flag.
- Wrap-around: ADD and SUB results are truncated modulo 32, with carry/borrow reported only via cf.
- No internal state other than the output registers. There is no dependency on previous operations, and no carry-in.
- All outputs must be X-free after the first reset edge.

Test Plan:
- Reset: rst=1 for one edge with arbitrary a/b/op -> R=00000, cf=0, sf=0, zf=1; release rst and confirm next edge computes normally.
- ADD with carry: a=10101, b=10001, op=00 -> after 1 edge R=00110, cf=1, sf=0, zf=0; ADD a=11111, b=00001 -> R=00000, cf=1, sf=0, zf=1.
- SUB: a=10101, b=10001, op=01 -> R=00100, cf=0, sf=0, zf=0; borrow case a=00011, b=00101 -> R=11110, cf=1, sf=1, zf=0; equal case a=b=01010 -> R=00000, cf=0, zf=1.
- Logic: a=10101, b=10001, op=10 -> R=10001, cf=0, sf=1, zf=0; op=11 -> R=10101, cf=0, sf=1, zf=0; AND a=01010, b=10101 -> R=00000, zf=1.
- Latency/pipelining: change op every cycle (00,01,10,11) with fixed a=10101, b=10001 -> outputs 00110, 00100, 10001, 10101 on successive edges, each one cycle after its inputs.
- Reset mid-stream: assert rst on the edge where ADD 11111+00001 is presented -> R=00000, cf=0, zf=1 (reset values, not the ADD carry).
